// File: rtl/mul_seq_ctrl.sv
// Iterative shift-add multiplier sequencer for the EX stage: accepts a MUL, stalls the
// pipeline while retiring BPC multiplier bits per cycle, then presents the low product bits.
module mul_seq_ctrl #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned BPC        = 1,
    parameter int unsigned EARLY_EXIT = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [4:0]       rd_i,
    output logic             stall_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic [4:0]       rd_o,
    output logic             busy_o
);

    localparam int unsigned N  = WIDTH / BPC;
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [WIDTH-1:0] acc_q;
    logic [CW-1:0]    count_q;
    logic [4:0]       rd_q;
    logic [WIDTH-1:0] result_q;
    logic [4:0]       rd_hold_q;

    logic [WIDTH-1:0] step_sum;
    logic [WIDTH-1:0] mcand_nxt;
    logic [WIDTH-1:0] mplier_nxt;
    logic             last_step;
    logic             in_done;

    // One RUN step: add the multiplicand shifted by each set low multiplier bit.
    always_comb begin
        step_sum = acc_q;
        for (int i = 0; i < int'(BPC); i++) begin
            if (mplier_q[i]) begin
                step_sum = step_sum + (mcand_q << i);
            end
        end
    end

    assign mcand_nxt  = mcand_q << BPC;
    assign mplier_nxt = mplier_q >> BPC;
    assign last_step  = (count_q == CW'(N - 1)) ||
                        ((EARLY_EXIT != 0) && (mplier_nxt == '0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            count_q   <= '0;
            rd_q      <= '0;
            result_q  <= '0;
            rd_hold_q <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start_i && !flush_i) begin
                        mcand_q  <= a_i;
                        mplier_q <= b_i;
                        rd_q     <= rd_i;
                        acc_q    <= '0;
                        count_q  <= '0;
                        state_q  <= StRun;
                    end
                end
                StRun: begin
                    if (flush_i) begin
                        state_q <= StIdle;
                    end else begin
                        acc_q    <= step_sum;
                        mcand_q  <= mcand_nxt;
                        mplier_q <= mplier_nxt;
                        count_q  <= count_q + 1'b1;
                        if (last_step) begin
                            state_q <= StDone;
                        end
                    end
                end
                StDone: begin
                    // A flushed completion must leave the held writeback values untouched.
                    if (!flush_i) begin
                        result_q  <= acc_q;
                        rd_hold_q <= rd_q;
                    end
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign in_done  = (state_q == StDone) && !flush_i;
    assign done_o   = in_done;
    assign result_o = in_done ? acc_q : result_q;
    assign rd_o     = in_done ? rd_q : rd_hold_q;
    assign busy_o   = (state_q != StIdle);
    assign stall_o  = ((state_q == StIdle) && start_i && !flush_i) || (state_q == StRun);

endmodule
